// File: rtl/port_resp.sv
// Output-port responder: round-robin grants among PORTNUM requesters and holds
// the port for the owner until its transfer completes or the watchdog expires.
module port_resp #(
  parameter int PORTNUM = 16,
  parameter int TIMEOUT = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [PORTNUM-1:0]         i_req,
  input  logic                       i_full,
  input  logic                       i_xfer_done,
  output logic                       o_port_ready,
  output logic [PORTNUM-1:0]         o_resp,
  output logic [PORTNUM-1:0]         o_nresp,
  output logic [$clog2(PORTNUM)-1:0] o_owner,
  output logic                       o_owner_vld,
  output logic                       o_timeout
);

  localparam int OW = $clog2(PORTNUM);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01
  } state_t;

  state_t              state, next_state;
  logic [OW-1:0]       rr_ptr, rr_d;
  logic [WW-1:0]       wdog, wdog_d;
  logic [OW-1:0]       win, idx;
  logic                found;
  logic [PORTNUM-1:0]  resp_d, nresp_d;
  logic [OW-1:0]       owner_d;
  logic                vld_d, timeout_d, ready_d;

  // Round-robin search starting just after the last winner; the index
  // wraps naturally because PORTNUM is a power of two.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= PORTNUM; i++) begin
      idx = rr_ptr + OW'(i);
      if (!found && i_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    resp_d     = '0;
    nresp_d    = '0;
    owner_d    = o_owner;
    vld_d      = o_owner_vld;
    timeout_d  = 1'b0;
    rr_d       = rr_ptr;
    wdog_d     = wdog;
    case (state)
      IDLE: begin
        if (|i_req) begin
          if (i_full) begin
            nresp_d = i_req;
          end else begin
            resp_d     = PORTNUM'(1) << win;
            nresp_d    = i_req & ~(PORTNUM'(1) << win);
            owner_d    = win;
            vld_d      = 1'b1;
            rr_d       = win;
            wdog_d     = '0;
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        // Done wins over a coinciding watchdog expiry.
        nresp_d = i_req;
        if (i_xfer_done) begin
          next_state = IDLE;
          vld_d      = 1'b0;
          wdog_d     = '0;
        end else if (wdog == WDOG_LAST) begin
          next_state = IDLE;
          timeout_d  = 1'b1;
          vld_d      = 1'b0;
          wdog_d     = '0;
        end else begin
          wdog_d = wdog + WW'(1);
        end
      end
      default: begin
        next_state = IDLE;
        vld_d      = 1'b0;
        wdog_d     = '0;
      end
    endcase
    ready_d = (next_state == IDLE) && !i_full;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      rr_ptr       <= OW'(PORTNUM - 1);
      wdog         <= '0;
      o_port_ready <= 1'b0;
      o_resp       <= '0;
      o_nresp      <= '0;
      o_owner      <= '0;
      o_owner_vld  <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state        <= next_state;
      rr_ptr       <= rr_d;
      wdog         <= wdog_d;
      o_port_ready <= ready_d;
      o_resp       <= resp_d;
      o_nresp      <= nresp_d;
      o_owner      <= owner_d;
      o_owner_vld  <= vld_d;
      o_timeout    <= timeout_d;
    end
  end

endmodule

// File: tb/tb_port_resp.sv
// Bench for port_resp: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level reference model.
module tb_port_resp;

  localparam int P = 16;
  localparam int T = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [P-1:0]  i_req = '0;
  logic          i_full = 1'b0;
  logic          i_xfer_done = 1'b0;
  logic          o_port_ready;
  logic [P-1:0]  o_resp;
  logic [P-1:0]  o_nresp;
  logic [3:0]    o_owner;
  logic          o_owner_vld;
  logic          o_timeout;

  int vectors = 0;
  int miscompares = 0;

  port_resp #(.PORTNUM(P), .TIMEOUT(T)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_full(i_full),
    .i_xfer_done(i_xfer_done), .o_port_ready(o_port_ready), .o_resp(o_resp),
    .o_nresp(o_nresp), .o_owner(o_owner), .o_owner_vld(o_owner_vld),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: tracks ownership as "granted at edge N", releases on done
  // or once T edges have elapsed since the grant.
  int           edge_n = 0;
  int           grant_edge = 0;
  int           rr = P - 1;
  bit           busy = 0;
  logic [P-1:0] e_resp = '0;
  logic [P-1:0] e_nresp = '0;
  logic [3:0]   e_owner = '0;
  bit           e_vld = 0;
  bit           e_to = 0;
  bit           e_ready = 0;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr = P - 1; busy = 0; e_resp = '0; e_nresp = '0; e_owner = '0;
      e_vld = 0; e_to = 0; e_ready = 0;
    end else begin
      int w;
      bit got;
      edge_n++;
      e_resp = '0; e_nresp = '0; e_to = 0;
      if (!busy) begin
        if (i_req != '0) begin
          if (i_full) begin
            e_nresp = i_req;
          end else begin
            got = 0; w = 0;
            for (int j = 1; j <= P; j++) begin
              if (!got && i_req[(rr + j) % P]) begin
                w = (rr + j) % P;
                got = 1;
              end
            end
            e_resp = '0;
            e_resp[w] = 1'b1;
            e_nresp = i_req & ~e_resp;
            e_owner = 4'(w);
            e_vld = 1; rr = w; busy = 1; grant_edge = edge_n;
          end
        end
      end else begin
        e_nresp = i_req;
        if (i_xfer_done) begin
          busy = 0; e_vld = 0;
        end else if (edge_n - grant_edge == T) begin
          busy = 0; e_vld = 0; e_to = 1;
        end
      end
      e_ready = !busy && !i_full;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    checkOutput("port_ready", 32'(o_port_ready), 32'(e_ready));
    checkOutput("resp", 32'(o_resp), 32'(e_resp));
    checkOutput("nresp", 32'(o_nresp), 32'(e_nresp));
    checkOutput("owner", 32'(o_owner), 32'(e_owner));
    checkOutput("owner_vld", 32'(o_owner_vld), 32'(e_vld));
    checkOutput("timeout", 32'(o_timeout), 32'(e_to));
  end

  task automatic applyStimulus(input logic [P-1:0] req, input logic full, input logic done);
    @(posedge i_clk);
    #1;
    i_req = req;
    i_full = full;
    i_xfer_done = done;
  endtask

  task automatic doReset();
    i_rst_n = 1'b0;
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    i_rst_n = 1'b1;
  endtask

  initial begin
    doReset();
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_ready_after_reset", 32'(o_port_ready), 32'd1);

    // Single request from port 3
    applyStimulus(16'h0008, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_resp_p3", 32'(o_resp), 32'h0008);
    checkOutput("lit_owner_p3", 32'(o_owner), 32'd3);
    checkOutput("lit_ready_grant", 32'(o_port_ready), 32'd0);
    applyStimulus('0, 1'b0, 1'b1);

    // Round-robin over ports 0, 2, 8
    doReset();
    applyStimulus(16'h0105, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_rr_first", 32'(o_resp), 32'h0001);
    checkOutput("lit_rr_first_nresp", 32'(o_nresp), 32'h0104);
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus(16'h0105, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_rr_second", 32'(o_resp), 32'h0004);
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus(16'h0105, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_rr_third", 32'(o_resp), 32'h0100);
    applyStimulus('0, 1'b0, 1'b1);

    // Requests while busy are all rejected
    applyStimulus(16'h0004, 1'b0, 1'b0);
    applyStimulus(16'h8001, 1'b0, 1'b0);
    checkOutput("lit_owner_p2", 32'(o_owner), 32'd2);
    applyStimulus('0, 1'b0, 1'b1);
    checkOutput("lit_busy_nresp", 32'(o_nresp), 32'h8001);
    checkOutput("lit_busy_resp", 32'(o_resp), 32'h0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_release_vld", 32'(o_owner_vld), 32'd0);
    checkOutput("lit_release_ready", 32'(o_port_ready), 32'd1);

    // Full downstream rejects, then grant once it clears
    applyStimulus(16'h0010, 1'b1, 1'b0);
    applyStimulus('0, 1'b1, 1'b0);
    checkOutput("lit_full_nresp", 32'(o_nresp), 32'h0010);
    checkOutput("lit_full_ready", 32'(o_port_ready), 32'd0);
    applyStimulus(16'h0010, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_after_full_resp", 32'(o_resp), 32'h0010);
    checkOutput("lit_after_full_owner", 32'(o_owner), 32'd4);
    applyStimulus('0, 1'b0, 1'b1);

    // Watchdog release exactly T cycles after the grant pulse
    applyStimulus(16'h0002, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_wd_grant", 32'(o_resp), 32'h0002);
    for (int i = 1; i < T; i++) applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_wd_early", 32'(o_timeout), 32'd0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_wd_pulse", 32'(o_timeout), 32'd1);
    checkOutput("lit_wd_vld", 32'(o_owner_vld), 32'd0);

    // Done coinciding with watchdog expiry suppresses the timeout pulse
    applyStimulus(16'h0002, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    for (int i = 1; i < T - 1; i++) applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b1);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_wd_done_to", 32'(o_timeout), 32'd0);
    checkOutput("lit_wd_done_vld", 32'(o_owner_vld), 32'd0);

    // Asynchronous reset in the middle of BUSY
    applyStimulus(16'h0080, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("lit_async_vld", 32'(o_owner_vld), 32'd0);
    checkOutput("lit_async_owner", 32'(o_owner), 32'd0);
    applyStimulus('0, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    applyStimulus(16'hFFFF, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);
    checkOutput("lit_async_rr", 32'(o_resp), 32'h0001);
    applyStimulus('0, 1'b0, 1'b1);

    // Continuous all-port requests: model enforces 0,1,2,... order
    for (int i = 0; i < 3 * P; i++) applyStimulus(16'hFFFF, 1'b0, i[0]);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [P-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? '0 : P'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 19) == 0) r = '1;
      applyStimulus(r, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end
    applyStimulus('0, 1'b0, 1'b0);
    applyStimulus('0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
